// File: rtl/serial_frame_deserializer_pkg.sv
// Shared types and helpers for the serial frame deserializer.
package deser_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // True when the data bits together with the parity bit contain an even number of ones.
    function automatic logic even_parity_ok(input logic [31:0] data, input logic p);
        return ~((^data) ^ p);
    endfunction

endpackage

// File: rtl/serial_frame_deserializer_out_buf.sv
// One-entry valid/ready holding register for received words, with overrun detection.
module deser_out_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         load_perr,
    input  logic         load_ferr,
    input  logic         data_ready,
    output logic [W-1:0] data_out,
    output logic         data_valid,
    output logic         parity_err,
    output logic         frame_err,
    output logic         overrun
);

    logic slot_free;

    // The slot can take a new word when it is empty or its word is being accepted right now.
    assign slot_free = !data_valid || data_ready;

    // Load committed words into the slot, drop them with an overrun pulse when it is still occupied.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (load && slot_free) begin
                data_out   <= load_data;
                parity_err <= load_perr;
                frame_err  <= load_ferr;
                data_valid <= 1'b1;
            end else begin
                if (load) begin
                    overrun <= 1'b1;
                end
                if (data_valid && data_ready) begin
                    data_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/serial_frame_deserializer.sv
// Collects framed serial bits (start, data LSB first, optional even parity, stop)
// into parallel words and hands them to a one-entry valid/ready output buffer.
module serial_frame_deserializer
    import deser_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_in,
    input  logic              bit_en,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    input  logic              data_ready,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] shift_reg;
    logic              parity_bit;
    logic              commit;
    logic              commit_perr;
    logic              commit_ferr;

    // Frame state machine: steps once per valid bit and places data bits by position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
        end else if (bit_en) begin
            case (state)
                IDLE: begin
                    if (bit_in == START_BIT) begin
                        state <= DATA;
                        cnt   <= '0;
                    end
                end
                DATA: begin
                    shift_reg[cnt] <= bit_in;
                    if (cnt == LAST_IDX) begin
                        cnt   <= '0;
                        state <= PARITY_EN ? PARITY : STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PARITY: begin
                    parity_bit <= bit_in;
                    state      <= STOP;
                end
                STOP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // The word is committed in the stop-bit cycle; a zero stop bit marks a framing error.
    assign commit      = bit_en && (state == STOP);
    assign commit_ferr = (bit_in != STOP_BIT);
    assign commit_perr = PARITY_EN ? ~even_parity_ok(32'(shift_reg), parity_bit) : 1'b0;

    deser_out_buf #(
        .W (DATA_W)
    ) u_out_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (commit),
        .load_data  (shift_reg),
        .load_perr  (commit_perr),
        .load_ferr  (commit_ferr),
        .data_ready (data_ready),
        .data_out   (data_out),
        .data_valid (data_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

endmodule

// File: tb/tb_serial_frame_deserializer.sv
// Self-checking bench for serial_frame_deserializer (DATA_W=8, PARITY_EN=1).
module tb_serial_frame_deserializer;

    logic       clk        = 1'b0;
    logic       rst_n      = 1'b0;
    logic       bit_in     = 1'b1;
    logic       bit_en     = 1'b0;
    logic       data_ready = 1'b1;
    logic [7:0] data_out;
    logic       data_valid;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } word_t;

    typedef struct {
        logic [7:0] d;
        logic       p;
        logic       s;
        logic       exp_pe;
        logic       exp_fe;
    } vec_t;

    // Driver-to-model handshake: a completed frame's stop bit is on the wire this cycle.
    logic  commit_now = 1'b0;
    word_t commit_word;
    logic  rand_ready = 1'b0;

    // Transaction-level model of the single-slot output buffer.
    word_t m_word;
    logic  m_valid = 1'b0;
    logic  m_ovr   = 1'b0;

    int    ovr_seen     = 0;
    int    valid_cycles = 0;
    word_t acc_q[$];

    serial_frame_deserializer #(
        .DATA_W    (8),
        .PARITY_EN (1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bit_in     (bit_in),
        .bit_en     (bit_en),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Drives one cycle of inputs on the falling edge.
    task automatic applyStimulus(input logic b, input logic en, input logic is_stop, input word_t w);
        @(negedge clk);
        bit_in      = b;
        bit_en      = en;
        commit_now  = en && is_stop;
        commit_word = w;
        if (rand_ready) begin
            data_ready = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                              input logic toggle, input logic holes);
        logic [10:0] bits;
        word_t       w;
        bits = {s, p, d, 1'b0};
        w.d  = d;
        w.pe = ((($countones(d) + int'(p)) % 2) != 0);
        w.fe = (s == 1'b0);
        for (int i = 0; i < 11; i++) begin
            if (holes && ($urandom_range(0, 3) == 0)) begin
                applyStimulus(1'b1, 1'b0, 1'b0, w);
            end
            applyStimulus(bits[i], 1'b1, (i == 10), w);
            if (toggle && (i < 10)) begin
                applyStimulus(1'b0, 1'b0, 1'b0, w);
            end
        end
    endtask

    // Checks DUT outputs against the buffer model shortly before each rising edge.
    always @(negedge clk) begin
        #3;
        if (!rst_n) begin
            m_valid = 1'b0;
            m_ovr   = 1'b0;
        end else begin
            if (data_valid) valid_cycles++;
            if (overrun) ovr_seen++;
            checkOutput("mon_valid", 32'(data_valid), 32'(m_valid));
            checkOutput("mon_overrun", 32'(overrun), 32'(m_ovr));
            if (m_valid) begin
                checkOutput("mon_data", 32'(data_out), 32'(m_word.d));
                checkOutput("mon_perr", 32'(parity_err), 32'(m_word.pe));
                checkOutput("mon_ferr", 32'(frame_err), 32'(m_word.fe));
            end
            if (data_valid && data_ready) begin
                acc_q.push_back('{d: data_out, pe: parity_err, fe: frame_err});
            end
            m_ovr = 1'b0;
            if (m_valid && data_ready) begin
                m_valid = 1'b0;
            end
            if (commit_now) begin
                if (!m_valid) begin
                    m_word  = commit_word;
                    m_valid = 1'b1;
                end else begin
                    m_ovr = 1'b1;
                end
            end
        end
    end

    initial begin
        vec_t  vec[9];
        word_t nw;
        int    vc0;
        int    ov0;
        int    q0;
        logic [7:0] rd;
        logic       rp;
        logic       rs;

        nw = '{d: 8'h00, pe: 1'b0, fe: 1'b0};
        vec[0] = '{d: 8'hA5, p: 1'b0, s: 1'b1, exp_pe: 1'b0, exp_fe: 1'b0};
        vec[1] = '{d: 8'hA5, p: 1'b1, s: 1'b1, exp_pe: 1'b1, exp_fe: 1'b0};
        vec[2] = '{d: 8'hA5, p: 1'b0, s: 1'b0, exp_pe: 1'b0, exp_fe: 1'b1};
        vec[3] = '{d: 8'h01, p: 1'b1, s: 1'b1, exp_pe: 1'b0, exp_fe: 1'b0};
        vec[4] = '{d: 8'h01, p: 1'b0, s: 1'b1, exp_pe: 1'b1, exp_fe: 1'b0};
        vec[5] = '{d: 8'hFF, p: 1'b0, s: 1'b1, exp_pe: 1'b0, exp_fe: 1'b0};
        vec[6] = '{d: 8'h00, p: 1'b0, s: 1'b1, exp_pe: 1'b0, exp_fe: 1'b0};
        vec[7] = '{d: 8'h80, p: 1'b0, s: 1'b0, exp_pe: 1'b1, exp_fe: 1'b1};
        vec[8] = '{d: 8'h3C, p: 1'b1, s: 1'b1, exp_pe: 1'b1, exp_fe: 1'b0};

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_data", 32'(data_out), 32'h0);
        checkOutput("rst_valid", 32'(data_valid), 32'h0);
        checkOutput("rst_perr", 32'(parity_err), 32'h0);
        checkOutput("rst_ferr", 32'(frame_err), 32'h0);
        checkOutput("rst_ovr", 32'(overrun), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, nw);

        // Table-driven single frames, consumer always ready
        data_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            send_frame(vec[i].d, vec[i].p, vec[i].s, 1'b0, 1'b0);
            applyStimulus(1'b1, 1'b0, 1'b0, nw);
            checkOutput($sformatf("tbl%0d_valid", i), 32'(data_valid), 32'h1);
            checkOutput($sformatf("tbl%0d_data", i), 32'(data_out), 32'(vec[i].d));
            checkOutput($sformatf("tbl%0d_perr", i), 32'(parity_err), 32'(vec[i].exp_pe));
            checkOutput($sformatf("tbl%0d_ferr", i), 32'(frame_err), 32'(vec[i].exp_fe));
            applyStimulus(1'b1, 1'b0, 1'b0, nw);
            checkOutput($sformatf("tbl%0d_drop", i), 32'(data_valid), 32'h0);
        end

        // Idle ones after a frame must not start a word
        vc0 = valid_cycles;
        repeat (12) applyStimulus(1'b1, 1'b1, 1'b0, nw);
        checkOutput("idle_no_word", 32'(valid_cycles - vc0), 32'h0);

        // Overrun: consumer stalled across two frames
        data_ready = 1'b0;
        ov0 = ovr_seen;
        send_frame(8'h3C, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, nw);
        checkOutput("ovr_first_data", 32'(data_out), 32'h3C);
        send_frame(8'hC3, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, nw);
        checkOutput("ovr_pulse", 32'(overrun), 32'h1);
        checkOutput("ovr_hold_data", 32'(data_out), 32'h3C);
        applyStimulus(1'b1, 1'b0, 1'b0, nw);
        checkOutput("ovr_pulse_end", 32'(overrun), 32'h0);
        checkOutput("ovr_hold_data2", 32'(data_out), 32'h3C);
        checkOutput("ovr_count", 32'(ovr_seen - ov0), 32'h1);
        data_ready = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, nw);
        checkOutput("ovr_release", 32'(data_valid), 32'h0);

        // Back-to-back frames with ready held high
        ov0 = ovr_seen;
        vc0 = valid_cycles;
        q0  = acc_q.size();
        send_frame(8'h01, 1'b1, 1'b1, 1'b0, 1'b0);
        send_frame(8'hFF, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, nw);
        checkOutput("b2b_ovr", 32'(ovr_seen - ov0), 32'h0);
        checkOutput("b2b_valid_cycles", 32'(valid_cycles - vc0), 32'h2);
        checkOutput("b2b_count", 32'(acc_q.size() - q0), 32'h2);
        if (acc_q.size() >= q0 + 2) begin
            checkOutput("b2b_word0", 32'(acc_q[q0].d), 32'h01);
            checkOutput("b2b_word1", 32'(acc_q[q0 + 1].d), 32'hFF);
        end

        // Bit enable toggling each cycle
        send_frame(8'h5A, 1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, nw);
        checkOutput("tog_valid", 32'(data_valid), 32'h1);
        checkOutput("tog_data", 32'(data_out), 32'h5A);
        checkOutput("tog_perr", 32'(parity_err), 32'h0);
        checkOutput("tog_ferr", 32'(frame_err), 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, nw);

        // Reset in the middle of a frame
        applyStimulus(1'b0, 1'b1, 1'b0, nw);
        repeat (4) applyStimulus(1'b1, 1'b1, 1'b0, nw);
        @(negedge clk);
        rst_n      = 1'b0;
        bit_en     = 1'b0;
        commit_now = 1'b0;
        #1;
        checkOutput("mid_rst_data", 32'(data_out), 32'h0);
        checkOutput("mid_rst_valid", 32'(data_valid), 32'h0);
        checkOutput("mid_rst_perr", 32'(parity_err), 32'h0);
        checkOutput("mid_rst_ferr", 32'(frame_err), 32'h0);
        checkOutput("mid_rst_ovr", 32'(overrun), 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, nw);
        applyStimulus(1'b0, 1'b1, 1'b0, nw);
        rst_n = 1'b1;
        bit_en = 1'b0;
        q0 = acc_q.size();
        send_frame(8'h81, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, nw);
        checkOutput("post_rst_count", 32'(acc_q.size() - q0), 32'h1);
        if (acc_q.size() >= q0 + 1) begin
            checkOutput("post_rst_data", 32'(acc_q[q0].d), 32'h81);
            checkOutput("post_rst_perr", 32'(acc_q[q0].pe), 32'h0);
            checkOutput("post_rst_ferr", 32'(acc_q[q0].fe), 32'h0);
        end

        // Randomized frames, gaps, enable holes and consumer stalls against the model
        rand_ready = 1'b1;
        for (int f = 0; f < 40; f++) begin
            repeat ($urandom_range(0, 3)) applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'b0, nw);
            rd = 8'($urandom);
            rp = 1'($urandom);
            rs = ($urandom_range(0, 9) != 0);
            send_frame(rd, rp, rs, 1'b0, 1'b1);
        end
        rand_ready = 1'b0;
        data_ready = 1'b1;
        repeat (4) applyStimulus(1'b1, 1'b0, 1'b0, nw);
        checkOutput("rand_drained", 32'(data_valid), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
